// File: rtl/imsic_setipnum_arb.sv
// Round-robin arbiter with a one-entry output buffer sharing the IMSIC setipnum write path.
// Optional identity filter: define IMSIC_ARB_ID_FILTER_EN to drop identities 0 and >= NR_SRC.
module imsic_setipnum_arb #(
    parameter int NR_REQ                = 2,
    parameter int NR_SRC_LEN            = 32,
    parameter int NR_SRC                = 64,
    parameter int NR_IMSICS             = 1,
    parameter int NR_VS_FILES_PER_IMSIC = 0,
    parameter int NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
    parameter int IMSIC_W               = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
    parameter int FILE_W                = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
) (
    input  logic                                                     i_clk,
    input  logic                                                     ni_rst,
    input  logic [NR_REQ-1:0]                                        i_req_valid,
    output logic [NR_REQ-1:0]                                        o_req_ready,
    input  logic [NR_REQ-1:0][IMSIC_W-1:0]                           i_req_imsic,
    input  logic [NR_REQ-1:0][FILE_W-1:0]                            i_req_file,
    input  logic [NR_REQ-1:0][NR_SRC_LEN-1:0]                        i_req_id,
    input  logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                  i_file_busy,
    output logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0][NR_SRC_LEN-1:0]  o_setipnum,
    output logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                  o_setipnum_we,
    output logic [15:0]                                              o_drop_cnt
);

    localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

`ifdef IMSIC_ARB_ID_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [IMSIC_W-1:0]    buf_imsic_q, buf_imsic_d;
    logic [FILE_W-1:0]     buf_file_q, buf_file_d;
    logic [NR_SRC_LEN-1:0] buf_id_q, buf_id_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] gnt;
    logic             found;
    logic             any_valid;
    logic             accept;
    logic             drop;
    logic             load;
    logic             drain;
    logic             sel_busy;
    logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0] tgt_hit;

    // Buffer target decode; the buffer only ever holds in-range targets.
    always_comb begin
        tgt_hit  = '0;
        sel_busy = 1'b0;
        for (int i = 0; i < NR_IMSICS; i++) begin
            for (int f = 0; f < NR_INTP_FILES; f++) begin
                tgt_hit[i][f] = buf_valid_q && (buf_imsic_q == IMSIC_W'(i)) &&
                                (buf_file_q == FILE_W'(f));
                sel_busy      = sel_busy | (tgt_hit[i][f] & i_file_busy[i][f]);
            end
        end
        drain = buf_valid_q && !sel_busy;
    end

    always_comb begin
        o_setipnum_we = '0;
        o_setipnum    = '0;
        for (int i = 0; i < NR_IMSICS; i++) begin
            for (int f = 0; f < NR_INTP_FILES; f++) begin
                if (drain && tgt_hit[i][f]) begin
                    o_setipnum_we[i][f] = 1'b1;
                    o_setipnum[i][f]    = buf_id_q;
                end
            end
        end
    end

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % NR_REQ);
            if (!found && i_req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        any_valid = |i_req_valid;
        accept    = any_valid && (!buf_valid_q || drain);
        drop      = (int'(i_req_imsic[gnt]) >= NR_IMSICS) ||
                    (int'(i_req_file[gnt]) >= NR_INTP_FILES) ||
                    (FILTER_EN && ((i_req_id[gnt] == '0) ||
                                   (i_req_id[gnt] >= NR_SRC_LEN'(NR_SRC))));
        load      = accept && !drop;

        o_req_ready = '0;
        for (int r = 0; r < NR_REQ; r++) begin
            o_req_ready[r] = accept && (gnt == PTR_W'(r));
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        buf_valid_d = buf_valid_q;
        buf_imsic_d = buf_imsic_q;
        buf_file_d  = buf_file_q;
        buf_id_d    = buf_id_q;
        drop_cnt_d  = drop_cnt_q;
        if (accept) begin
            rr_ptr_d = PTR_W'((int'(gnt) + 1) % NR_REQ);
        end
        if (drain) begin
            buf_valid_d = 1'b0;
        end
        if (load) begin
            buf_valid_d = 1'b1;
            buf_imsic_d = i_req_imsic[gnt];
            buf_file_d  = i_req_file[gnt];
            buf_id_d    = i_req_id[gnt];
        end
        if (accept && drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            rr_ptr_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_imsic_q <= '0;
            buf_file_q  <= '0;
            buf_id_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            buf_valid_q <= buf_valid_d;
            buf_imsic_q <= buf_imsic_d;
            buf_file_q  <= buf_file_d;
            buf_id_q    <= buf_id_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_imsic_setipnum_arb.sv
// Bench for imsic_setipnum_arb: directed cases plus randomized traffic against a queue-based model.
module tb_imsic_setipnum_arb;
  localparam int NREQ  = 3;
  localparam int NIMS  = 1;
  localparam int NFILE = 3;
  localparam int SL    = 32;
  localparam int NSRC  = 64;
  localparam int EW    = 1 + 2 + SL;

`ifdef IMSIC_ARB_ID_FILTER_EN
  localparam logic [2:0]  T5_WE   = 3'b000;
  localparam logic [31:0] T5_D2   = 32'd0;
  localparam logic [15:0] T5_DCNT = 16'd4;
`else
  localparam logic [2:0]  T5_WE   = 3'b100;
  localparam logic [31:0] T5_D2   = 32'd64;
  localparam logic [15:0] T5_DCNT = 16'd2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0]                   valid;
  logic [NREQ-1:0]                   ready;
  logic [NREQ-1:0][0:0]              imsic;
  logic [NREQ-1:0][1:0]              file;
  logic [NREQ-1:0][SL-1:0]           id;
  logic [NIMS-1:0][NFILE-1:0]        busy;
  logic [NIMS-1:0][NFILE-1:0][SL-1:0] setip;
  logic [NIMS-1:0][NFILE-1:0]        we;
  logic [15:0]                       dcnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  imsic_setipnum_arb #(
    .NR_REQ(NREQ), .NR_SRC_LEN(SL), .NR_SRC(NSRC), .NR_IMSICS(NIMS),
    .NR_VS_FILES_PER_IMSIC(1)
  ) dut (
    .i_clk(clk), .ni_rst(rst_n), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_imsic(imsic), .i_req_file(file), .i_req_id(id), .i_file_busy(busy),
    .o_setipnum(setip), .o_setipnum_we(we), .o_drop_cnt(dcnt)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic bit is_drop(int im, int fi, int unsigned idv);
    bit d;
    d = (im >= NIMS) || (fi >= NFILE);
`ifdef IMSIC_ARB_ID_FILTER_EN
    if (idv == 0 || idv >= NSRC) d = 1'b1;
`endif
    return d;
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int r, int im, int fi, int unsigned idv);
    valid[r] = 1'b1;
    imsic[r] = 1'(im);
    file[r]  = 2'(fi);
    id[r]    = 32'(idv);
  endtask

  task automatic clr_req(int r);
    valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_req(int r);
    int im, fi;
    int unsigned idv;
    im = ($urandom_range(0, 15) == 0) ? 1 : 0;
    fi = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
    case ($urandom_range(0, 9))
      0:       idv = 0;
      1:       idv = 64 + $urandom_range(0, 100);
      default: idv = $urandom_range(1, 63);
    endcase
    set_req(r, im, fi, idv);
  endtask

  // reference model: pointer, one-slot buffer, drop counter
  int          m_rr   = 0;
  bit          m_bv   = 1'b0;
  logic [EW-1:0] m_buf = '0;
  int unsigned m_dcnt = 0;

  always @(negedge clk) begin
    int g;
    bit m_drain, m_acc;
    logic [2:0] exp_rdy;
    if (!rst_n) begin
      m_rr = 0; m_bv = 1'b0; m_dcnt = 0;
      exp_q.delete();
      check("reset_we", we, '0);
      check("reset_data", setip, '0);
      check("reset_drop_cnt", dcnt, '0);
    end else begin
      check("drop_cnt", dcnt, 16'(m_dcnt));
      m_drain = m_bv && !busy[m_buf[EW-1]][m_buf[SL+1:SL]];
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
      m_acc   = (g >= 0) && (!m_bv || m_drain);
      exp_rdy = m_acc ? 3'(1 << g) : 3'b000;
      check("ready", ready, exp_rdy);
      if (m_drain) begin
        exp_q.push_back(m_buf);
        m_bv = 1'b0;
      end
      if (m_acc) begin
        m_rr = (g + 1) % NREQ;
        if (is_drop(int'(imsic[g]), int'(file[g]), id[g])) begin
          if (m_dcnt < 65535) m_dcnt++;
        end else begin
          m_buf = {imsic[g], file[g], id[g]};
          m_bv  = 1'b1;
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [NIMS-1:0][NFILE-1:0] ew;
    logic [NIMS-1:0][NFILE-1:0][SL-1:0] es;
    #1;
    if (rst_n) begin
      if (we != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", we, '0);
        end else begin
          e  = exp_q.pop_front();
          ew = '0;
          es = '0;
          ew[e[EW-1]][e[SL+1:SL]] = 1'b1;
          es[e[EW-1]][e[SL+1:SL]] = e[SL-1:0];
          check("strobe_we", we, ew);
          check("strobe_data", setip, es);
        end
      end
      check("pending_writes", exp_q.size(), 0);
      exp_q.delete();
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] rdy_seen;
    rst_n = 1'b0; valid = '0; imsic = '0; file = '0; id = '0; busy = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, '0);
    check("rst_we", we, '0);
    check("rst_data", setip, '0);
    check("rst_drop", dcnt, '0);

    // single request
    cyc();
    set_req(0, 0, 1, 5);
    @(negedge clk); check("t1_ready", ready, 3'b001);
    cyc(); clr_req(0);
    @(negedge clk); check("t1_we", we, 3'b010); check("t1_data", setip[0][1], 32'd5);

    // round robin from a fresh pointer
    do_reset();
    set_req(0, 0, 0, 3);
    set_req(1, 0, 0, 7);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t2_grant", ready, (c % 2 == 0) ? 3'b001 : 3'b010);
      if (c > 0) begin
        check("t2_we", we, 3'b001);
        check("t2_data", setip[0][0], (c % 2 == 1) ? 32'd3 : 32'd7);
      end
      cyc();
    end
    clr_req(0); clr_req(1);
    cyc();

    // backpressure
    busy[0][0] = 1'b1;
    set_req(0, 0, 0, 9);
    @(negedge clk); check("t3_load", ready, 3'b001);
    cyc(); clr_req(0); set_req(1, 0, 1, 11);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); check("t3_stall_ready", ready, '0); check("t3_stall_we", we, '0);
      cyc();
      if (c == 3) busy[0][0] = 1'b0;
    end
    @(negedge clk);
    check("t3_we", we, 3'b001); check("t3_data", setip[0][0], 32'd9); check("t3_ready1", ready, 3'b010);
    cyc(); clr_req(1);
    @(negedge clk); check("t3_we2", we, 3'b010); check("t3_data2", setip[0][1], 32'd11);
    cyc();

    // out-of-range targets
    set_req(0, 0, 3, 20);
    @(negedge clk); check("t4_ready", ready, 3'b001);
    cyc(); set_req(0, 1, 0, 21);
    @(negedge clk); check("t4_we", we, '0); check("t4_cnt1", dcnt, 16'd1); check("t4_ready2", ready, 3'b001);
    cyc(); clr_req(0);
    @(negedge clk); check("t4_we2", we, '0); check("t4_cnt2", dcnt, 16'd2);
    cyc();

    // identity filter
    set_req(0, 0, 2, 0);
    @(negedge clk); check("t5_ready0", ready, 3'b001);
    cyc(); set_req(0, 0, 2, 64);
    @(negedge clk); check("t5_ready1", ready, 3'b001); check("t5_we0", we, T5_WE);
    check("t5_data0", setip[0][2], 32'd0);
    cyc(); clr_req(0);
    @(negedge clk); check("t5_we1", we, T5_WE); check("t5_data1", setip[0][2], T5_D2);
    check("t5_cnt", dcnt, T5_DCNT);
    cyc();

    // reset while the buffered write is stalled
    busy[0][2] = 1'b1;
    set_req(0, 0, 2, 4);
    @(negedge clk); check("t6_ready", ready, 3'b001);
    cyc(); clr_req(0);
    @(negedge clk); check("t6_stall", we, '0);
    cyc();
    #2 rst_n = 1'b0;
    #1 check("t6_we_now", we, '0); check("t6_data_now", setip, '0); check("t6_cnt_now", dcnt, '0);
    cyc(); busy = '0;
    cyc(); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); check("t6_no_strobe", we, '0);
      cyc();
    end
    set_req(0, 0, 0, 12); set_req(1, 0, 1, 13);
    @(negedge clk); check("t6_rr_zero", ready, 3'b001);
    cyc(); clr_req(0); clr_req(1);
    repeat (3) cyc();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rdy_seen = ready;
      cyc();
      for (int r = 0; r < NREQ; r++) begin
        if (valid[r] && rdy_seen[r]) begin
          if ($urandom_range(0, 2) == 0) clr_req(r); else rand_req(r);
        end else if (!valid[r] && $urandom_range(0, 9) < 6) begin
          rand_req(r);
        end
      end
      for (int f = 0; f < NFILE; f++) busy[0][f] = ($urandom_range(0, 2) == 0);
    end
    valid = '0; busy = '0;
    repeat (4) cyc();

    // drop counter saturation
    do_reset();
    set_req(0, 0, 3, 1);
    repeat (65540) cyc();
    clr_req(0);
    @(negedge clk); check("sat_cnt", dcnt, 16'hFFFF);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
